pattern_generator: RTL
======================

# pattern_generator

Serial test-pattern transmitter for the FSM exercise board. It loads a parallel bit pattern on a start request and drives it out LSB-first, one bit per enable strobe, on a single serial line. The strobe comes from the board timer. The line feeds the pattern-detecting FSMs, so detector behaviour can be exercised without pressing buttons. Optional repeat mode loops the pattern until stopped.

## Interface
Parameters:
- WIDTH, 8: maximum pattern length in bits.
- LEN_W, $clog2(WIDTH+1): width of the length port.
- IDLE_LEVEL, 1'b1: level driven on `a` when not transmitting.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  bit-rate strobe, one clock wide.
- start  in  1  transmit request, sampled every clock.
- stop  in  1  synchronous abort.
- pattern  in  WIDTH  bits to send; bit 0 is sent first.
- length  in  LEN_W  number of bits to send. 0 or any value >WIDTH means WIDTH.
- repeat  in  1  loop the pattern until stop.
- a  out  1  serial data (registered).
- valid  out  1  high while `a` carries a pattern bit.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-clock pulse when a non-repeat transmission completes.

## Operation
- States: IDLE, ARMED, SEND.
- IDLE:
  - Outputs: a=IDLE_LEVEL, valid=0, busy=0.
  - start=1 and stop=0 captures pattern into shadow and shift registers. It also captures the effective length into len_q and repeat into rep_q, clears cnt, and moves to ARMED.
- ARMED:
  - `a` holds IDLE_LEVEL, busy=1.
  - On enable: a<=shift[0], shift>>=1, cnt<=1, valid<=1, move to SEND.
- SEND, on enable:
  - If cnt<len_q: a<=shift[0], shift>>=1, cnt++.
  - If cnt==len_q and rep_q=1: reload shift from shadow, a<=shadow[0], cnt<=1. There is no gap between repetitions.
  - If cnt==len_q and rep_q=0: a<=IDLE_LEVEL, valid<=0, done<=1 for one clock, move to IDLE.
- stop=1 in ARMED or SEND: go to IDLE next clock with a=IDLE_LEVEL and valid=0. done is not asserted. stop has priority over enable.
- start while busy is ignored. Inputs change only at start; pattern, length and repeat changes during busy have no effect.
- Simultaneous start and stop in IDLE: stop wins, remain IDLE.
- reset_n low at any time:
  - state=IDLE, a=IDLE_LEVEL, valid=0, busy=0, done=0.
  - shift, shadow and cnt are cleared.
  - A transmission in progress is abandoned.
- cnt width is LEN_W. It never exceeds len_q, so no wrap-around occurs.

## Timing
- start→busy: 1 clock (busy is combinational from state).
- First bit appears on `a` the clock after the first enable following start.
- Bit k (0-based) is held from the clock after enable k until the clock after enable k+1. Each bit lasts exactly one enable period.
- done is asserted the clock after the (len_q+1)-th enable. `a` returns to IDLE_LEVEL in that same clock.
- A new start is accepted the clock after done.
- enable arriving in the same clock as start is not consumed. The first bit waits for the next enable.

## Structure
- Shared package fsm_pkg:
  - state encoding parameters IDLE=2'd0, ARMED=2'd1, SEND=2'd2;
  - default-state handling (illegal encodings return to IDLE);
  - IDLE_LEVEL default.
- Sub-module pattern_gen_shifter contains shadow, shift and cnt, with load/shift/reload controls and a last-bit flag. The top level keeps only the FSM and output registers.
- A board top instantiates the existing timer for `enable`.

## Test plan
- WIDTH=8, pattern=8'b0000_0110, length=3, repeat=0, one start pulse:
  - `a` = 0,1,1 on successive enable periods, valid high for 3 periods;
  - one done pulse, then a=1 and busy=0.
- length=0, pattern=8'hA5:
  - 8 bits 1,0,1,0,0,1,0,1 are sent, done follows the 9th enable.
- repeat=1, pattern=8'b10, length=2:
  - `a` alternates 0,1,0,1… with no idle gap over 6 periods;
  - stop mid-bit gives a=1, valid=0, busy=0 next clock, no done.
- start pulsed again during SEND with a different pattern: the original sequence completes unchanged.
- reset_n asserted during bit 2 of 8: `a` goes to 1 asynchronously and busy=0. After release, a start sends a full fresh pattern from bit 0.
- start and enable in the same clock: first bit appears only after the next enable. start and stop together in IDLE: busy stays 0.

Source files
------------

// File: rtl/fsm_pkg.sv
// fsm_pkg: shared state encoding, illegal-state recovery and idle line level for the board FSMs
package fsm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, SEND = 2'd2} state_e;
  localparam logic IDLE_LEVEL_DEF = 1'b1;
  function automatic state_e legal_state(input state_e s);
    return (s == ARMED || s == SEND) ? s : IDLE;
  endfunction
endpackage

// File: rtl/pattern_generator_if.sv
// pattern_generator_if: control inputs and serial outputs of the pattern generator
interface pattern_generator_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
);
  logic             enable_i;
  logic             start_i;
  logic             stop_i;
  logic             repeat_i;
  logic [WIDTH-1:0] pattern_i;
  logic [LEN_W-1:0] length_i;
  logic             a_o;
  logic             valid_o;
  logic             busy_o;
  logic             done_o;
  modport master (
    output enable_i, start_i, stop_i, repeat_i, pattern_i, length_i,
    input  a_o, valid_o, busy_o, done_o
  );
  modport slave (
    input  enable_i, start_i, stop_i, repeat_i, pattern_i, length_i,
    output a_o, valid_o, busy_o, done_o
  );
endinterface

// File: rtl/pattern_gen_shifter.sv
// pattern_gen_shifter: shadow/shift registers and bit counter with a last-bit flag
module pattern_gen_shifter #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic             reload_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             bit_o,
  output logic             last_o
);
  logic [WIDTH-1:0] shadow_q, shift_q;
  logic [LEN_W-1:0] cnt_q, len_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
    end else if (load_i) begin
      shadow_q <= pattern_i;
      shift_q  <= pattern_i;
      cnt_q    <= '0;
      len_q    <= len_i;
    end else if (reload_i) begin
      shift_q <= shadow_q >> 1;
      cnt_q   <= LEN_W'(1);
    end else if (adv_i) begin
      shift_q <= shift_q >> 1;
      cnt_q   <= cnt_q + LEN_W'(1);
    end
  end
  assign last_o = cnt_q == len_q;
  // at the end of a pass the next bit comes from the shadow copy (repeat wrap)
  assign bit_o  = last_o ? shadow_q[0] : shift_q[0];
endmodule

// File: rtl/pattern_generator.sv
// pattern_generator: loads a parallel pattern on start and sends it LSB-first, one bit per enable strobe
module pattern_generator
  import fsm_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   LEN_W      = $clog2(WIDTH + 1),
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input logic                 clock,
  input logic                 reset_n,
  pattern_generator_if.slave  pg
);
  localparam logic [LEN_W-1:0] WMAX = LEN_W'(WIDTH);
  state_e           state_q, state_d;
  logic             a_q, a_d, valid_q, valid_d, done_q, done_d, rep_q, rep_d;
  logic             load, adv, reload, next_bit, last;
  logic [LEN_W-1:0] len_eff;
  assign len_eff = (pg.length_i == '0 || pg.length_i > WMAX) ? WMAX : pg.length_i;
  pattern_gen_shifter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_shifter (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_i    (load),
    .adv_i     (adv),
    .reload_i  (reload),
    .pattern_i (pg.pattern_i),
    .len_i     (len_eff),
    .bit_o     (next_bit),
    .last_o    (last)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    rep_d   = rep_q;
    load    = 1'b0;
    adv     = 1'b0;
    reload  = 1'b0;
    case (legal_state(state_q))
      ARMED, SEND: begin
        // stop outranks enable in both active states
        if (pg.stop_i) begin
          state_d = IDLE;
          a_d     = IDLE_LEVEL;
          valid_d = 1'b0;
        end else if (pg.enable_i) begin
          if (state_q == ARMED || !last) begin
            a_d     = next_bit;
            valid_d = 1'b1;
            adv     = 1'b1;
            state_d = SEND;
          end else if (rep_q) begin
            a_d    = next_bit;
            reload = 1'b1;
          end else begin
            a_d     = IDLE_LEVEL;
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        a_d     = IDLE_LEVEL;
        valid_d = 1'b0;
        if (pg.start_i && !pg.stop_i) begin
          load    = 1'b1;
          rep_d   = pg.repeat_i;
          state_d = ARMED;
        end
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= IDLE_LEVEL;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      rep_q   <= rep_d;
    end
  end
  assign pg.a_o     = a_q;
  assign pg.valid_o = valid_q;
  assign pg.done_o  = done_q;
  assign pg.busy_o  = state_q != IDLE;
endmodule
